// File: rtl/multicycle_control_fsm_pkg.sv
// Shared constants for the multicycle control unit: opcodes, R-type functs,
// to_alu class codes, FSM state encodings and decoded instruction classes.
// Optional feature macro: CTRL_ILLEGAL_TRAP_EN (adds the TRAP state).
package multicycle_control_fsm_pkg;

  localparam int OP_BITS    = 6;
  localparam int ALUOP_BITS = 3;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LI    = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // R-type functs
  localparam logic [5:0] FN_JR  = 6'b001000;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // to_alu class codes
  localparam logic [2:0] ALU_R    = 3'b000;
  localparam logic [2:0] ALU_ORI  = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_LI   = 3'b011;
  localparam logic [2:0] ALU_BR   = 3'b100;
  localparam logic [2:0] ALU_JMP  = 3'b101;
  localparam logic [2:0] ALU_ANDI = 3'b110;
  localparam logic [2:0] ALU_SLTI = 3'b111;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC   = 4'd2,
    S_ALUWB  = 4'd3,
    S_MEMADR = 4'd4,
    S_MEMRD  = 4'd5,
    S_MEMWR  = 4'd6,
    S_MEMWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_LIWB   = 4'd10
`ifdef CTRL_ILLEGAL_TRAP_EN
   ,S_TRAP   = 4'd11
`endif
  } state_t;

  typedef enum logic [3:0] {
    CLS_ILLEGAL,
    CLS_RTYPE,
    CLS_JR,
    CLS_IMM,
    CLS_LW,
    CLS_SW,
    CLS_BRANCH,
    CLS_JUMP,
    CLS_LI
  } instr_class_t;

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Control/memory bundle between the multicycle FSM (master) and the datapath +
// shared memory (slave). Inputs to the FSM: op, funct, mem_ready, zero.
// Outputs from the FSM: memory request strobes and all datapath control lines.
interface multicycle_control_fsm_if;
  import multicycle_control_fsm_pkg::*;

  logic [OP_BITS-1:0]    op;
  logic [OP_BITS-1:0]    funct;
  logic                  mem_ready;
  logic                  zero;
  logic                  mem_req;
  logic                  mem_write;
  logic                  pc_write;
  logic                  ir_write;
  logic                  mem_to_reg;
  logic                  alu_src;
  logic                  r_type;
  logic                  reg_wr;
  logic                  reg_dst;
  logic                  beq;
  logic                  bne;
  logic                  jump;
  logic                  li;
  logic                  link;
  logic [ALUOP_BITS-1:0] to_alu;
  logic                  instr_done;

  modport master (
    input  op, funct, mem_ready, zero,
    output mem_req, mem_write, pc_write, ir_write, mem_to_reg, alu_src, r_type,
           reg_wr, reg_dst, beq, bne, jump, li, link, to_alu, instr_done
  );

  modport slave (
    output op, funct, mem_ready, zero,
    input  mem_req, mem_write, pc_write, ir_write, mem_to_reg, alu_src, r_type,
           reg_wr, reg_dst, beq, bne, jump, li, link, to_alu, instr_done
  );

endinterface

// File: rtl/multicycle_control_fsm_ctrl_opcode_decode.sv
// Combinational op/funct -> instruction class + to_alu code; shared with the
// single-cycle control unit. Ports: op, funct in; cls, to_alu out.
// Unlisted opcodes and unlisted R-type functs decode as CLS_ILLEGAL.
module ctrl_opcode_decode
  import multicycle_control_fsm_pkg::*;
(
  input  logic [OP_BITS-1:0]    op,
  input  logic [OP_BITS-1:0]    funct,
  output instr_class_t          cls,
  output logic [ALUOP_BITS-1:0] to_alu
);

  always_comb begin
    cls    = CLS_ILLEGAL;
    to_alu = ALU_R;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_JR:                                  cls = CLS_JR;
          FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT:  cls = CLS_RTYPE;
          default:                                cls = CLS_ILLEGAL;
        endcase
      end
      OP_ORI:        begin cls = CLS_IMM;    to_alu = ALU_ORI;  end
      OP_ADDI:       begin cls = CLS_IMM;    to_alu = ALU_ADD;  end
      OP_ANDI:       begin cls = CLS_IMM;    to_alu = ALU_ANDI; end
      OP_SLTI:       begin cls = CLS_IMM;    to_alu = ALU_SLTI; end
      OP_LW:         begin cls = CLS_LW;     to_alu = ALU_ADD;  end
      OP_SW:         begin cls = CLS_SW;     to_alu = ALU_ADD;  end
      OP_BEQ, OP_BNE: begin cls = CLS_BRANCH; to_alu = ALU_BR;  end
      OP_J, OP_JAL:  begin cls = CLS_JUMP;   to_alu = ALU_JMP;  end
      OP_LI:         begin cls = CLS_LI;     to_alu = ALU_LI;   end
      default:       begin cls = CLS_ILLEGAL; to_alu = ALU_R;   end
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle control FSM: sequences each instruction FETCH/DECODE/EXEC/MEM/WB,
// handshakes with a shared memory and counts retired instructions.
// Ports: clk, rst_n, bus (control/memory interface), retired, state_o[, trap].
// Macro CTRL_ILLEGAL_TRAP_EN: unknown op/funct parks the FSM in TRAP with trap=1.
module multicycle_control_fsm
  import multicycle_control_fsm_pkg::*;
#(
  parameter int OP_W    = OP_BITS,
  parameter int ALUOP_W = ALUOP_BITS,
  parameter int CNT_W   = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  multicycle_control_fsm_if.master bus,
  output logic [CNT_W-1:0]        retired,
  output logic [3:0]              state_o
`ifdef CTRL_ILLEGAL_TRAP_EN
 ,output logic                    trap
`endif
);

  state_t               state, state_n;
  logic [OP_W-1:0]      op_q, funct_q, dec_op, dec_funct;
  instr_class_t         cls;
  logic [ALUOP_W-1:0]   dec_to_alu;

  logic mem_req_q, mem_write_q, pc_write_q, mem_to_reg_q, alu_src_q, r_type_q;
  logic reg_wr_q, reg_dst_q, beq_q, bne_q, jump_q, li_q, link_q, done_q;
  logic [ALUOP_W-1:0] to_alu_q;
  logic instr_done;

  // In DECODE the IR fields are live on the bus; afterwards use the latched copy.
  assign dec_op    = (state == S_DECODE) ? bus.op    : op_q;
  assign dec_funct = (state == S_DECODE) ? bus.funct : funct_q;

  ctrl_opcode_decode u_dec (
    .op     (dec_op),
    .funct  (dec_funct),
    .cls    (cls),
    .to_alu (dec_to_alu)
  );

  always_comb begin
    state_n = state;
    case (state)
      S_FETCH:  if (bus.mem_ready) state_n = S_DECODE;
      S_DECODE: begin
        case (cls)
          CLS_RTYPE, CLS_IMM: state_n = S_EXEC;
          CLS_JR, CLS_JUMP:   state_n = S_JUMP;
          CLS_LW, CLS_SW:     state_n = S_MEMADR;
          CLS_BRANCH:         state_n = S_BRANCH;
          CLS_LI:             state_n = S_LIWB;
`ifdef CTRL_ILLEGAL_TRAP_EN
          default:            state_n = S_TRAP;
`else
          default:            state_n = S_FETCH;
`endif
        endcase
      end
      S_EXEC:   state_n = S_ALUWB;
      S_MEMADR: state_n = (cls == CLS_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (bus.mem_ready) state_n = S_MEMWB;
      S_MEMWR:  if (bus.mem_ready) state_n = S_FETCH;
`ifdef CTRL_ILLEGAL_TRAP_EN
      S_TRAP:   state_n = S_TRAP;
`endif
      default:  state_n = S_FETCH;
    endcase
  end

  // Outputs are registered from the state being entered, so they are pure
  // functions of the current state and latched op once that state is live.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_FETCH;
      op_q         <= '0;
      funct_q      <= '0;
      retired      <= '0;
      mem_req_q    <= 1'b1;
      mem_write_q  <= 1'b0;
      pc_write_q   <= 1'b0;
      mem_to_reg_q <= 1'b0;
      alu_src_q    <= 1'b0;
      r_type_q     <= 1'b0;
      reg_wr_q     <= 1'b0;
      reg_dst_q    <= 1'b0;
      beq_q        <= 1'b0;
      bne_q        <= 1'b0;
      jump_q       <= 1'b0;
      li_q         <= 1'b0;
      link_q       <= 1'b0;
      done_q       <= 1'b0;
      to_alu_q     <= '0;
    end else begin
      state <= state_n;
      if (state == S_DECODE) begin
        op_q    <= bus.op;
        funct_q <= bus.funct;
      end
      if (instr_done) retired <= retired + 1'b1;

      mem_req_q    <= 1'b0;
      mem_write_q  <= 1'b0;
      pc_write_q   <= 1'b0;
      mem_to_reg_q <= 1'b0;
      alu_src_q    <= 1'b0;
      r_type_q     <= 1'b0;
      reg_wr_q     <= 1'b0;
      reg_dst_q    <= 1'b0;
      beq_q        <= 1'b0;
      bne_q        <= 1'b0;
      jump_q       <= 1'b0;
      li_q         <= 1'b0;
      link_q       <= 1'b0;
      done_q       <= 1'b0;
      to_alu_q     <= '0;

      case (state_n)
        S_FETCH:  mem_req_q <= 1'b1;
        S_EXEC: begin
          to_alu_q  <= dec_to_alu;
          alu_src_q <= (cls != CLS_RTYPE);
          r_type_q  <= (cls == CLS_RTYPE);
        end
        S_ALUWB: begin
          reg_wr_q  <= 1'b1;
          r_type_q  <= (cls == CLS_RTYPE);
          reg_dst_q <= (cls == CLS_RTYPE);
          done_q    <= 1'b1;
        end
        S_MEMADR: begin
          to_alu_q  <= ALU_ADD;
          alu_src_q <= 1'b1;
        end
        S_MEMRD:  mem_req_q <= 1'b1;
        S_MEMWR: begin
          mem_req_q   <= 1'b1;
          mem_write_q <= 1'b1;
        end
        S_MEMWB: begin
          reg_wr_q     <= 1'b1;
          mem_to_reg_q <= 1'b1;
          done_q       <= 1'b1;
        end
        S_BRANCH: begin
          to_alu_q <= ALU_BR;
          beq_q    <= (dec_op == OP_BEQ);
          bne_q    <= (dec_op == OP_BNE);
          done_q   <= 1'b1;
        end
        S_JUMP: begin
          jump_q     <= 1'b1;
          pc_write_q <= 1'b1;
          to_alu_q   <= ALU_JMP;
          r_type_q   <= (cls == CLS_JR);
          link_q     <= (dec_op == OP_JAL);
          reg_wr_q   <= (dec_op == OP_JAL);
          done_q     <= 1'b1;
        end
        S_LIWB: begin
          li_q      <= 1'b1;
          to_alu_q  <= ALU_LI;
          alu_src_q <= 1'b1;
          reg_wr_q  <= 1'b1;
          done_q    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Strobes that complete on a memory handshake or depend on the ALU flag are
  // qualified by the live input in their state.
  assign instr_done     = done_q | ((state == S_MEMWR) & bus.mem_ready);
  assign bus.instr_done = instr_done;
  assign bus.ir_write   = (state == S_FETCH) & bus.mem_ready;
  assign bus.pc_write   = pc_write_q
                        | ((state == S_FETCH) & bus.mem_ready)
                        | ((state == S_BRANCH) & ((beq_q & bus.zero) | (bne_q & ~bus.zero)));
  assign bus.mem_req    = mem_req_q;
  assign bus.mem_write  = mem_write_q;
  assign bus.mem_to_reg = mem_to_reg_q;
  assign bus.alu_src    = alu_src_q;
  assign bus.r_type     = r_type_q;
  assign bus.reg_wr     = reg_wr_q;
  assign bus.reg_dst    = reg_dst_q;
  assign bus.beq        = beq_q;
  assign bus.bne        = bne_q;
  assign bus.jump       = jump_q;
  assign bus.li         = li_q;
  assign bus.link       = link_q;
  assign bus.to_alu     = to_alu_q;
  assign state_o        = state;

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic trap_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) trap_q <= 1'b0;
    else        trap_q <= (state_n == S_TRAP);
  end
  assign trap = trap_q;
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm with a 4-bit retired counter so the
// wrap can be reached. Each instruction is run to completion while the control
// outputs seen in every non-FETCH cycle are accumulated and compared.
module tb_multicycle_control_fsm;
  import multicycle_control_fsm_pkg::*;

  localparam int CW = 4;

  logic          clk;
  logic          rst_n;
  logic [CW-1:0] retired;
  logic [3:0]    state_o;
`ifdef CTRL_ILLEGAL_TRAP_EN
  logic          trap;
`endif

  multicycle_control_fsm_if bus ();

  multicycle_control_fsm #(.CNT_W(CW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .retired (retired),
    .state_o (state_o)
`ifdef CTRL_ILLEGAL_TRAP_EN
   ,.trap    (trap)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_ret = 0;
  int ncyc;

  // Accumulated over the non-FETCH cycles of one instruction
  logic [15:0] vis;
  int a_pcw, a_jump, a_link, a_regwr, a_regdst, a_rtype, a_done, a_m2r;
  int a_mreq, a_memw, a_beq, a_bne, a_li, a_alusrc, a_toalu;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Entered at posedge+1 with the FSM in FETCH; returns at posedge+1 once back
  // in FETCH (or parked in TRAP). mem_ready is held low for `waits` cycles of
  // the memory data phase.
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                           input int waits, output int cycles);
    int  w;
    bit  fin;
    logic [3:0] st;
    vis = '0; a_pcw = 0; a_jump = 0; a_link = 0; a_regwr = 0; a_regdst = 0;
    a_rtype = 0; a_done = 0; a_m2r = 0; a_mreq = 0; a_memw = 0; a_beq = 0;
    a_bne = 0; a_li = 0; a_alusrc = 0; a_toalu = 0;
    w = 0; fin = 0; cycles = 0;
    bus.op = o; bus.funct = f; bus.zero = z;
    for (int i = 0; i < 40 && !fin; i++) begin
      @(negedge clk);
      st = state_o;
      if ((st == 4'd5 || st == 4'd6) && w < waits) begin
        bus.mem_ready = 1'b0;
        w++;
      end else begin
        bus.mem_ready = 1'b1;
      end
      #1;
      vis = vis | (16'd1 << st);
      if (st != 4'd0) begin
        a_pcw    |= int'(bus.pc_write);
        a_jump   |= int'(bus.jump);
        a_link   |= int'(bus.link);
        a_regwr  |= int'(bus.reg_wr);
        a_regdst |= int'(bus.reg_dst);
        a_rtype  |= int'(bus.r_type);
        a_m2r    |= int'(bus.mem_to_reg);
        a_memw   |= int'(bus.mem_write);
        a_beq    |= int'(bus.beq);
        a_bne    |= int'(bus.bne);
        a_li     |= int'(bus.li);
        a_alusrc |= int'(bus.alu_src);
        a_toalu  |= int'(bus.to_alu);
        a_done   += int'(bus.instr_done);
        if ((st == 4'd5 || st == 4'd6) && bus.mem_req) a_mreq++;
      end
      @(posedge clk);
      #1;
      cycles++;
      if (state_o == 4'd0 || state_o == 4'd11) fin = 1;
    end
    if (!fin) check("instr_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout required $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    bus.op = '0; bus.funct = '0; bus.mem_ready = 1'b0; bus.zero = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset state (mem_ready low so FETCH waits)
    check("rst_state",   32'(state_o),        32'd0);
    check("rst_mem_req", 32'(bus.mem_req),    32'd1);
    check("rst_retired", 32'(retired),        32'd0);
    check("rst_reg_wr",  32'(bus.reg_wr),     32'd0);
    check("rst_pc_write",32'(bus.pc_write),   32'd0);
    check("rst_done",    32'(bus.instr_done), 32'd0);

    // lw aborted by reset while waiting in MEMRD
    bus.op = OP_LW; bus.mem_ready = 1'b1;
    @(posedge clk); #1;             // DECODE
    @(posedge clk); #1;             // MEMADR
    bus.mem_ready = 1'b0;
    @(posedge clk); #1;             // MEMRD, stalled
    check("abort_in_memrd", 32'(state_o),     32'd5);
    check("abort_memrd_req",32'(bus.mem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_state",   32'(state_o),    32'd0);
    check("abort_mem_req", 32'(bus.mem_req),32'd1);
    check("abort_retired", 32'(retired),    32'd0);
    check("abort_reg_wr",  32'(bus.reg_wr), 32'd0);
    @(negedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // addi
    run_instr(OP_ADDI, 6'd0, 1'b0, 0, ncyc); exp_ret++;
    check("addi_cycles", 32'(ncyc),     32'd4);
    check("addi_states", 32'(vis),      32'h000F);
    check("addi_to_alu", 32'(a_toalu),  32'd2);
    check("addi_alu_src",32'(a_alusrc), 32'd1);
    check("addi_reg_wr", 32'(a_regwr),  32'd1);
    check("addi_reg_dst",32'(a_regdst), 32'd0);
    check("addi_done",   32'(a_done),   32'd1);
    check("addi_retired",32'(retired),  32'(exp_ret % 16));

    // R-type add
    run_instr(OP_RTYPE, FN_ADD, 1'b0, 0, ncyc); exp_ret++;
    check("add_cycles", 32'(ncyc),     32'd4);
    check("add_to_alu", 32'(a_toalu),  32'd0);
    check("add_reg_dst",32'(a_regdst), 32'd1);
    check("add_r_type", 32'(a_rtype),  32'd1);
    check("add_alu_src",32'(a_alusrc), 32'd0);
    check("add_retired",32'(retired),  32'(exp_ret % 16));

    // lw with 3 wait cycles in MEMRD
    run_instr(OP_LW, 6'd0, 1'b0, 3, ncyc); exp_ret++;
    check("lw_cycles",    32'(ncyc),   32'd8);
    check("lw_states",    32'(vis),    32'h00B3);
    check("lw_mem_req",   32'(a_mreq), 32'd4);
    check("lw_mem_to_reg",32'(a_m2r),  32'd1);
    check("lw_mem_write", 32'(a_memw), 32'd0);
    check("lw_done",      32'(a_done), 32'd1);
    check("lw_retired",   32'(retired),32'(exp_ret % 16));

    // sw, no wait
    run_instr(OP_SW, 6'd0, 1'b0, 0, ncyc); exp_ret++;
    check("sw_cycles",   32'(ncyc),    32'd4);
    check("sw_states",   32'(vis),     32'h0053);
    check("sw_mem_write",32'(a_memw),  32'd1);
    check("sw_reg_wr",   32'(a_regwr), 32'd0);
    check("sw_done",     32'(a_done),  32'd1);
    check("sw_retired",  32'(retired), 32'(exp_ret % 16));

    // Branches
    run_instr(OP_BEQ, 6'd0, 1'b1, 0, ncyc); exp_ret++;
    check("beq_cycles",  32'(ncyc),   32'd3);
    check("beq_states",  32'(vis),    32'h0103);
    check("beq_z1_pcw",  32'(a_pcw),  32'd1);
    check("beq_flag",    32'(a_beq),  32'd1);
    check("beq_to_alu",  32'(a_toalu),32'd4);
    check("beq_done",    32'(a_done), 32'd1);
    run_instr(OP_BNE, 6'd0, 1'b1, 0, ncyc); exp_ret++;
    check("bne_z1_pcw",  32'(a_pcw),  32'd0);
    check("bne_flag",    32'(a_bne),  32'd1);
    check("bne_done",    32'(a_done), 32'd1);
    run_instr(OP_BNE, 6'd0, 1'b0, 0, ncyc); exp_ret++;
    check("bne_z0_pcw",  32'(a_pcw),  32'd1);
    check("br_retired",  32'(retired),32'(exp_ret % 16));

    // Jumps
    run_instr(OP_JAL, 6'd0, 1'b0, 0, ncyc); exp_ret++;
    check("jal_cycles", 32'(ncyc),    32'd3);
    check("jal_states", 32'(vis),     32'h0203);
    check("jal_jump",   32'(a_jump),  32'd1);
    check("jal_link",   32'(a_link),  32'd1);
    check("jal_reg_wr", 32'(a_regwr), 32'd1);
    check("jal_pcw",    32'(a_pcw),   32'd1);
    check("jal_to_alu", 32'(a_toalu), 32'd5);
    run_instr(OP_RTYPE, FN_JR, 1'b0, 0, ncyc); exp_ret++;
    check("jr_states",  32'(vis),     32'h0203);
    check("jr_jump",    32'(a_jump),  32'd1);
    check("jr_reg_wr",  32'(a_regwr), 32'd0);
    check("jr_link",    32'(a_link),  32'd0);
    check("jr_retired", 32'(retired), 32'(exp_ret % 16));

    // li
    run_instr(OP_LI, 6'd0, 1'b0, 0, ncyc); exp_ret++;
    check("li_cycles", 32'(ncyc),     32'd3);
    check("li_states", 32'(vis),      32'h0403);
    check("li_flag",   32'(a_li),     32'd1);
    check("li_to_alu", 32'(a_toalu),  32'd3);
    check("li_alu_src",32'(a_alusrc), 32'd1);
    check("li_reg_wr", 32'(a_regwr),  32'd1);
    check("li_retired",32'(retired),  32'(exp_ret % 16));

`ifndef CTRL_ILLEGAL_TRAP_EN
    // Unknown opcode is a NOP
    run_instr(6'b111111, 6'd0, 1'b0, 0, ncyc);
    check("nop_cycles", 32'(ncyc),    32'd2);
    check("nop_states", 32'(vis),     32'h0003);
    check("nop_done",   32'(a_done),  32'd0);
    check("nop_retired",32'(retired), 32'(exp_ret % 16));
`endif

    // Counter wrap 15 -> 0
    while ((exp_ret % 16) != 15) begin
      run_instr(OP_LI, 6'd0, 1'b0, 0, ncyc); exp_ret++;
    end
    check("cnt_at_max", 32'(retired), 32'd15);
    run_instr(OP_LI, 6'd0, 1'b0, 0, ncyc); exp_ret++;
    check("cnt_wrap",   32'(retired), 32'd0);

`ifdef CTRL_ILLEGAL_TRAP_EN
    run_instr(6'b111111, 6'd0, 1'b0, 0, ncyc);
    check("trap_state", 32'(state_o), 32'd11);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("trap_held",    32'(trap),         32'd1);
      check("trap_mem_req", 32'(bus.mem_req),  32'd0);
      check("trap_pcw",     32'(bus.pc_write), 32'd0);
      @(posedge clk); #1;
    end
    check("trap_retired", 32'(retired), 32'd0);
    rst_n = 1'b0; #1;
    check("trap_rst_state", 32'(state_o),     32'd0);
    check("trap_rst_trap",  32'(trap),        32'd0);
    check("trap_rst_req",   32'(bus.mem_req), 32'd1);
    rst_n = 1'b1;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
